// File: rtl/alu_resp_tx.sv
// Response packet framer: serialises {opcode, 0x00, RESP_LEN[15:0], result LSB-first}
// as a byte stream towards uart_tx.
module alu_resp_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned RESULT_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [7:0]              opcode_i,
   input  logic [RESULT_WIDTH-1:0] result_i,
   input  logic                    result_valid_i,
   output logic                    result_ready_o,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    busy_o
);

   localparam int unsigned RESP_LEN = 4 + RESULT_WIDTH / 8;
   localparam int unsigned CNT_W    = $clog2(RESP_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(RESP_LEN - 1);
   localparam logic [CNT_W-1:0] FIRST_PLD = CNT_W'(4);
   localparam logic [15:0]      LEN16     = 16'(RESP_LEN);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [7:0]              op_q;
   logic [RESULT_WIDTH-1:0] res_q;
   logic [DATA_WIDTH-1:0]   tdata_q;
   logic                    tvalid_q;
   logic                    ready_q;
   logic                    busy_q;
   logic [7:0]              byte_d;

   // Packet byte at a given position, built from the captured opcode/result.
   function automatic logic [7:0] byte_sel(input logic [CNT_W-1:0] idx);
      int unsigned             i;
      logic [RESULT_WIDTH-1:0] sh;
      i  = 32'(idx);
      sh = '0;
      if (i == 0)      byte_sel = op_q;
      else if (i == 1) byte_sel = 8'h00;
      else if (i == 2) byte_sel = LEN16[7:0];
      else if (i == 3) byte_sel = LEN16[15:8];
      else begin
         sh       = res_q >> (8 * (i - 4));
         byte_sel = sh[7:0];
      end
   endfunction

   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      byte_d = byte_sel(cnt_d);
   end

   // Framer FSM; every output comes straight from a register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         res_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (result_valid_i && ready_q) begin
                  op_q     <= opcode_i;
                  res_q    <= result_i;
                  cnt_q    <= '0;
                  tdata_q  <= DATA_WIDTH'(opcode_i);
                  tvalid_q <= 1'b1;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= HEADER;
               end
            end
            HEADER, PAYLOAD: begin
               if (tvalid_q && m_axis_tready) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_q    <= '0;
                     tdata_q  <= '0;
                     tvalid_q <= 1'b0;
                     ready_q  <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     cnt_q   <= cnt_d;
                     tdata_q <= DATA_WIDTH'(byte_d);
                     state_q <= (cnt_d < FIRST_PLD) ? HEADER : PAYLOAD;
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               tvalid_q <= 1'b0;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign result_ready_o = ready_q;
   assign m_axis_tdata   = tdata_q;
   assign m_axis_tvalid  = tvalid_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_alu_resp_tx.sv
// Directed bench for alu_resp_tx: packet contents, stalls, back-to-back,
// capture isolation, async reset mid-packet and a 16-bit result build.
module tb_alu_resp_tx;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  opcode;
   logic [31:0] result;
   logic        rvalid;
   logic        rready;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        busy;

   logic [7:0]  op16;
   logic [15:0] res16;
   logic        v16;
   logic        rdy16;
   logic [7:0]  tdata16;
   logic        tvalid16;
   logic        tready16;
   logic        busy16;

   alu_resp_tx #(.DATA_WIDTH(8), .RESULT_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .result_i(result),
      .result_valid_i(rvalid), .result_ready_o(rready),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .busy_o(busy)
   );

   alu_resp_tx #(.DATA_WIDTH(8), .RESULT_WIDTH(16)) dut16 (
      .clk_i(clk), .rst_i(rst), .opcode_i(op16), .result_i(res16),
      .result_valid_i(v16), .result_ready_o(rdy16),
      .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16), .m_axis_tready(tready16),
      .busy_o(busy16)
   );

   typedef struct {
      logic [7:0]  op;
      logic [31:0] res;
      bit          rnd;
      logic [63:0] exp;   // byte0 in [7:0]
   } vec_t;

   vec_t        vecs[4];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  got[16];
   int          ngot;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive tready each cycle, record transferred bytes and check stall stability.
   task automatic run_stream(input int n, input bit rnd, output int cycles);
      bit         drop   = 1'b0;
      bit         pstall = 1'b0;
      logic [7:0] pd     = 8'h00;
      ngot   = 0;
      cycles = 0;
      while (ngot < n && cycles < 400) begin
         @(negedge clk);
         if (drop) begin
            rvalid = 1'b0;
            drop   = 1'b0;
         end
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         cycles++;
         if (pstall) begin
            check("stall_tvalid_held", 64'(tvalid), 64'd1);
            check("stall_tdata_stable", 64'(tdata), 64'(pd));
         end
         pstall = tvalid && !tready;
         pd     = tdata;
         if (rvalid && rready) drop = 1'b1;
         if (tvalid && tready) begin
            got[ngot] = tdata;
            ngot++;
            check("ready_low_in_packet", 64'(rready), 64'd0);
         end
         @(posedge clk);
      end
      if (ngot < n) check("stream_timeout", 64'(ngot), 64'(n));
   endtask

   task automatic idle_checks(input string tag);
      check({tag, "_ready"},  64'(rready), 64'd1);
      check({tag, "_tvalid"}, 64'(tvalid), 64'd0);
      check({tag, "_busy"},   64'(busy),   64'd0);
   endtask

   initial begin
      int          cyc;
      logic [63:0] e;
      logic [7:0]  b2b[16];
      logic [7:0]  g16[6];
      logic [7:0]  e16[6];
      int          n16;

      vecs[0] = '{op: 8'h01, res: 32'h12345678, rnd: 1'b0, exp: 64'h12345678_00080001};
      vecs[1] = '{op: 8'h01, res: 32'h12345678, rnd: 1'b1, exp: 64'h12345678_00080001};
      vecs[2] = '{op: 8'hA5, res: 32'h00000000, rnd: 1'b0, exp: 64'h00000000_000800A5};
      vecs[3] = '{op: 8'hFF, res: 32'hFFFFFFFF, rnd: 1'b1, exp: 64'hFFFFFFFF_000800FF};

      rst = 1'b1; opcode = '0; result = '0; rvalid = 1'b0; tready = 1'b0;
      op16 = '0; res16 = '0; v16 = 1'b0; tready16 = 1'b1;
      #2;
      check("rst_tdata", 64'(tdata), 64'h0);
      idle_checks("rst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      idle_checks("post_rst");

      // Table-driven packets; inputs are scrambled right after acceptance.
      for (int v = 0; v < 4; v++) begin
         @(negedge clk);
         opcode = vecs[v].op; result = vecs[v].res; rvalid = 1'b1; tready = 1'b1;
         @(posedge clk);
         #1;
         rvalid = 1'b0; opcode = 8'h5A; result = 32'hA5A5_0F0F;
         check($sformatf("v%0d_latency_tvalid", v), 64'(tvalid), 64'd1);
         check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
         check($sformatf("v%0d_ready_low", v), 64'(rready), 64'd0);
         run_stream(8, vecs[v].rnd, cyc);
         e = vecs[v].exp;
         for (int i = 0; i < 8; i++)
            check($sformatf("v%0d_byte%0d", v, i), 64'(got[i]), 64'(e[i*8 +: 8]));
         if (!vecs[v].rnd) check($sformatf("v%0d_cycles", v), 64'(cyc), 64'd8);
         #1;
         idle_checks($sformatf("v%0d_end", v));
      end

      // Back-to-back with result_valid_i held: one idle cycle between packets.
      b2b = '{8'h02, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h03, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      @(negedge clk);
      opcode = 8'h02; result = 32'hDEADBEEF; rvalid = 1'b1; tready = 1'b1;
      @(posedge clk);
      #1;
      opcode = 8'h03; result = 32'h00000001;
      run_stream(16, 1'b0, cyc);
      for (int i = 0; i < 16; i++)
         check($sformatf("b2b_byte%0d", i), 64'(got[i]), 64'(b2b[i]));
      check("b2b_cycles", 64'(cyc), 64'd17);
      #1;
      idle_checks("b2b_end");

      // Asynchronous reset in the middle of a packet, after byte 5.
      @(negedge clk);
      opcode = 8'h04; result = 32'h11223344; rvalid = 1'b1; tready = 1'b1;
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      run_stream(6, 1'b0, cyc);
      check("rst_mid_byte5", 64'(got[5]), 64'h33);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid_tdata", 64'(tdata), 64'h0);
      idle_checks("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("no_trailing_bytes", 64'(tvalid), 64'd0);
      end
      @(negedge clk);
      opcode = 8'h06; result = 32'hCAFEF00D; rvalid = 1'b1;
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      run_stream(8, 1'b0, cyc);
      e = 64'hCAFEF00D_00080006;
      for (int i = 0; i < 8; i++)
         check($sformatf("after_rst_byte%0d", i), 64'(got[i]), 64'(e[i*8 +: 8]));

      // 16-bit result build: 6-byte packet.
      e16 = '{8'h10, 8'h00, 8'h06, 8'h00, 8'hCD, 8'hAB};
      @(negedge clk);
      op16 = 8'h10; res16 = 16'hABCD; v16 = 1'b1;
      @(posedge clk);
      #1;
      v16 = 1'b0; op16 = 8'hEE; res16 = 16'h1111;
      n16 = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (tvalid16) begin
            if (n16 < 6) g16[n16] = tdata16;
            n16++;
         end
      end
      check("w16_count", 64'(n16), 64'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("w16_byte%0d", i), 64'(g16[i]), 64'(e16[i]));
      check("w16_ready_end", 64'(rdy16), 64'd1);
      check("w16_busy_end", 64'(busy16), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
